// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types, default sizing and floor mask helpers for the elevator car controller
package elevator_pkg;

  localparam int DEF_NUM_FLOORS    = 6;
  localparam int DEF_TRAVEL_CYCLES = 50;
  localparam int DEF_DOOR_CYCLES   = 100;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR_OPEN = 2'd3
  } car_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Masks are always 8 wide; floors beyond NUM_FLOORS see zero request bits.
  function automatic logic [7:0] above_mask(input logic [2:0] floor);
    logic [7:0] m;
    for (int f = 0; f < 8; f++) begin
      m[f] = (f > int'(floor));
    end
    return m;
  endfunction

  function automatic logic [7:0] below_mask(input logic [2:0] floor);
    logic [7:0] m;
    for (int f = 0; f < 8; f++) begin
      m[f] = (f < int'(floor));
    end
    return m;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - down-counter timing both travel hops and door dwell
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         expire
);

  logic [W-1:0] count;

  // Loading N-1 makes the interval last N cycles, ending on the expire cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = enable && (count == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// rtl/elevator_car_ctrl.sv - single-car elevator controller with direction-preferring request service
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [NUM_FLOORS-1:0] done,
  output logic [2:0]            cur_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  car_state_t            state;
  car_state_t            nxt_state;
  dir_t                  dir;
  logic [7:0]            req_ext;
  logic [2:0]            ev_floor;
  logic [2:0]            nxt_floor;
  logic                  here;
  logic                  any_above;
  logic                  any_below;
  logic                  tmr_load;
  logic [TW-1:0]         tmr_val;
  logic                  tmr_expire;
  logic [NUM_FLOORS-1:0] done_nxt;

  // While moving, requests are judged from the floor being arrived at.
  always_comb begin
    req_ext = '0;
    req_ext[NUM_FLOORS-1:0] = req;
    case (state)
      S_MOVE_UP:   ev_floor = cur_floor + 3'd1;
      S_MOVE_DOWN: ev_floor = cur_floor - 3'd1;
      default:     ev_floor = cur_floor;
    endcase
    here      = req_ext[ev_floor];
    any_above = |(req_ext & above_mask(ev_floor));
    any_below = |(req_ext & below_mask(ev_floor));
  end

  always_comb begin
    nxt_state = state;
    nxt_floor = cur_floor;
    case (state)
      S_IDLE: begin
        if (here) begin
          nxt_state = S_DOOR_OPEN;
        end else if (any_above && ((dir == DIR_UP) || !any_below)) begin
          nxt_state = S_MOVE_UP;
        end else if (any_below) begin
          nxt_state = S_MOVE_DOWN;
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (tmr_expire) begin
          nxt_floor = ev_floor;
          if (here) begin
            nxt_state = S_DOOR_OPEN;
          end else if ((state == S_MOVE_UP) ? any_above : any_below) begin
            nxt_state = state;
          end else begin
            nxt_state = S_IDLE;
          end
        end
      end
      S_DOOR_OPEN: begin
        if (tmr_expire) begin
          nxt_state = S_IDLE;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    tmr_load = (state == S_IDLE) || tmr_expire;
    tmr_val  = (nxt_state == S_DOOR_OPEN) ? TW'(DOOR_CYCLES - 1) : TW'(TRAVEL_CYCLES - 1);

    for (int f = 0; f < NUM_FLOORS; f++) begin
      done_nxt[f] = (nxt_state == S_DOOR_OPEN) && (nxt_floor == 3'(f));
    end
  end

  cycle_timer #(
    .W(TW)
  ) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .enable   (state != S_IDLE),
    .expire   (tmr_expire)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= S_IDLE;
      dir         <= DIR_UP;
      cur_floor   <= 3'd0;
      done        <= '0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      state       <= nxt_state;
      cur_floor   <= nxt_floor;
      done        <= done_nxt;
      moving_up   <= (nxt_state == S_MOVE_UP);
      moving_down <= (nxt_state == S_MOVE_DOWN);
      door_open   <= (nxt_state == S_DOOR_OPEN);
      if (nxt_state == S_MOVE_UP) begin
        dir <= DIR_UP;
      end else if (nxt_state == S_MOVE_DOWN) begin
        dir <= DIR_DOWN;
      end
    end
  end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb/tb_elevator_car_ctrl.sv - directed bench for elevator_car_ctrl with request-cell model
module tb_elevator_car_ctrl;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_UP   = 3'b100;
  localparam logic [2:0] ST_DN   = 3'b010;
  localparam logic [2:0] ST_DOOR = 3'b001;

  logic       Clock;
  logic       Reset;
  logic [5:0] req;
  logic [5:0] done;
  logic [2:0] cur_floor;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;

  int checks;
  int failures;

  elevator_car_ctrl #(
    .NUM_FLOORS    (6),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .req         (req),
    .done        (done),
    .cur_floor   (cur_floor),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open)
  );

  always #5 Clock = ~Clock;

  function automatic logic [11:0] ev(input logic [2:0] st, input logic [2:0] fl, input logic [5:0] dn);
    return {st, fl, dn};
  endfunction

  function automatic logic [11:0] obs();
    return {moving_up, moving_down, door_open, cur_floor, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Request cells drop a latched bit once the car acknowledges it.
  task automatic tick();
    @(posedge Clock);
    #1;
    req = req & ~done;
  endtask

  task automatic expect_n(input int n, input string tag, input logic [11:0] e);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, 32'(obs()), 32'(e));
    end
  endtask

  task automatic do_reset(input logic [5:0] r);
    Reset = 1'b0;
    req   = r;
    tick();
    tick();
    check("reset_state", 32'(obs()), 32'(ev(ST_IDLE, 3'd0, 6'd0)));
    Reset = 1'b1;
  endtask

  initial begin
    Clock    = 1'b0;
    Reset    = 1'b0;
    req      = '0;
    checks   = 0;
    failures = 0;

    // Two hops up to floor 2 and service
    do_reset(6'b000100);
    expect_n(4, "a_up_f0", ev(ST_UP, 3'd0, 6'd0));
    expect_n(4, "a_up_f1", ev(ST_UP, 3'd1, 6'd0));
    expect_n(3, "a_door_f2", ev(ST_DOOR, 3'd2, 6'b000100));
    expect_n(1, "a_idle_f2", ev(ST_IDLE, 3'd2, 6'd0));

    // Current-floor request opens immediately
    do_reset(6'b000001);
    expect_n(3, "b_door_f0", ev(ST_DOOR, 3'd0, 6'b000001));
    expect_n(2, "b_idle_f0", ev(ST_IDLE, 3'd0, 6'd0));

    // Reach floor 3 going up, then split request: up first, then down
    do_reset(6'b001000);
    for (int f = 0; f < 3; f++) expect_n(4, "c_up_setup", ev(ST_UP, 3'(f), 6'd0));
    expect_n(3, "c_door_f3", ev(ST_DOOR, 3'd3, 6'b001000));
    expect_n(1, "c_idle_f3", ev(ST_IDLE, 3'd3, 6'd0));
    req = 6'b100001;
    expect_n(4, "c_up_f3", ev(ST_UP, 3'd3, 6'd0));
    expect_n(4, "c_up_f4", ev(ST_UP, 3'd4, 6'd0));
    expect_n(3, "c_door_f5", ev(ST_DOOR, 3'd5, 6'b100000));
    expect_n(1, "c_idle_f5", ev(ST_IDLE, 3'd5, 6'd0));
    for (int f = 5; f > 0; f--) expect_n(4, "c_down", ev(ST_DN, 3'(f), 6'd0));
    expect_n(3, "c_door_f0", ev(ST_DOOR, 3'd0, 6'b000001));
    expect_n(1, "c_idle_f0", ev(ST_IDLE, 3'd0, 6'd0));

    // Mid-hop request at the next floor stops the car there
    do_reset(6'b001000);
    expect_n(2, "d_up_f0", ev(ST_UP, 3'd0, 6'd0));
    req[1] = 1'b1;
    expect_n(2, "d_up_f0_late", ev(ST_UP, 3'd0, 6'd0));
    expect_n(3, "d_door_f1", ev(ST_DOOR, 3'd1, 6'b000010));
    expect_n(1, "d_idle_f1", ev(ST_IDLE, 3'd1, 6'd0));

    // Asynchronous reset in the middle of a door dwell
    do_reset(6'b010000);
    for (int f = 0; f < 4; f++) expect_n(4, "e_up", ev(ST_UP, 3'(f), 6'd0));
    expect_n(2, "e_door_f4", ev(ST_DOOR, 3'd4, 6'b010000));
    Reset = 1'b0;
    #1;
    check("e_async_reset", 32'(obs()), 32'(ev(ST_IDLE, 3'd0, 6'd0)));
    expect_n(2, "e_reset_hold", ev(ST_IDLE, 3'd0, 6'd0));
    req   = '0;
    Reset = 1'b1;
    expect_n(3, "e_after_reset", ev(ST_IDLE, 3'd0, 6'd0));

    // Re-press at the top floor while door is open is absorbed
    do_reset(6'b100000);
    for (int f = 0; f < 5; f++) expect_n(4, "f_up", ev(ST_UP, 3'(f), 6'd0));
    expect_n(2, "f_door_f5", ev(ST_DOOR, 3'd5, 6'b100000));
    req[5] = 1'b1;
    expect_n(1, "f_door_repress", ev(ST_DOOR, 3'd5, 6'b100000));
    expect_n(2, "f_idle_no_reopen", ev(ST_IDLE, 3'd5, 6'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_car_ctrl.md
ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 6, number of floors served (2..8).
REQ-002 Parameter TRAVEL_CYCLES, default 50, clock cycles to move one floor (>=1).
REQ-003 Parameter DOOR_CYCLES, default 100, clock cycles the door stays open (>=1).
REQ-004 Clock  input  1  single rising-edge clock for all state.
REQ-005 Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 req  input  NUM_FLOORS  level requests, bit f high = floor f latched by its request cell.
REQ-007 done  output  NUM_FLOORS  service acknowledge to request cells, bit f clears floor f.
REQ-008 cur_floor  output  3  current car floor, binary, 0..NUM_FLOORS-1.
REQ-009 moving_up / moving_down  output  1 each  high while in MOVE_UP / MOVE_DOWN.
REQ-010 door_open  output  1  high while in DOOR_OPEN.

Function
REQ-011 FSM states SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; a direction register dir (UP/DOWN) SHALL hold the last travel direction.
REQ-012 IDLE: req[cur_floor]=1 -> DOOR_OPEN next cycle, with priority over all other requests.
REQ-013 IDLE, no current-floor request: any req above and (dir=UP or no req below) -> MOVE_UP, dir<=UP; else any req below -> MOVE_DOWN, dir<=DOWN; else stay IDLE.
REQ-014 MOVE_UP/MOVE_DOWN SHALL last exactly TRAVEL_CYCLES cycles; on the final edge cur_floor SHALL increment/decrement by 1.
REQ-015 On that arrival edge: req[new floor]=1 -> DOOR_OPEN; else req still ahead in dir -> re-enter same MOVE state (timer reloaded); else -> IDLE.
REQ-016 cur_floor SHALL never exceed NUM_FLOORS-1 nor go below 0; MOVE_UP SHALL never be entered at top floor, MOVE_DOWN never at floor 0.
REQ-017 DOOR_OPEN SHALL last exactly DOOR_CYCLES cycles, then -> IDLE.
REQ-018 done[cur_floor] SHALL be 1 every cycle in DOOR_OPEN; all other done bits 0; done=0 in all other states.
REQ-019 A press at cur_floor during DOOR_OPEN SHALL be absorbed (cleared by done) with no reopen.
REQ-020 Request changes during MOVE SHALL NOT alter current hop; evaluated only at arrival.
REQ-021 req bits at index >= NUM_FLOORS SHALL not exist; simultaneous above/below requests resolved per REQ-013 (continue in dir).
REQ-022 Outputs moving_up, moving_down, door_open, done SHALL be decoded from registered state only (no req-to-output combinational path).

Reset
REQ-023 Reset=0 SHALL immediately force: state IDLE, dir UP, cur_floor 0, timer 0, done 0, door_open 0, moving_up 0, moving_down 0.
REQ-024 Reset asserted mid-MOVE or mid-DOOR_OPEN SHALL abandon the operation; car restarts at floor 0 with no done pulse.
REQ-025 First state evaluation SHALL occur on the first rising Clock edge after Reset returns to 1.

Structure
REQ-026 Package elevator_pkg SHALL hold the state enum, dir type, and default NUM_FLOORS/TRAVEL_CYCLES/DOOR_CYCLES constants.
REQ-027 One sub-module, cycle_timer (load value, enable, expire flag, width $clog2 of max(TRAVEL_CYCLES,DOOR_CYCLES)+1), SHALL time both MOVE and DOOR_OPEN.
REQ-028 Any-above/any-below request masks SHALL be computed combinationally from req and cur_floor.

Verification (bench parameters NUM_FLOORS=6, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-029 Reset, req=000100 held -> MOVE_UP 4 cycles, cur_floor=1, MOVE_UP 4 cycles, cur_floor=2, DOOR_OPEN 3 cycles with done=000100, then IDLE.
REQ-030 At floor 0 IDLE, req=000001 -> DOOR_OPEN next cycle, done=000001 for 3 cycles, no movement.
REQ-031 Car at floor 3 dir UP, req=100001 -> goes up to 5 first, door, then down to 0.
REQ-032 During MOVE_UP 0->1, req[1] rises mid-hop -> car stops at floor 1 (arrival evaluation), DOOR_OPEN entered.
REQ-033 Reset=0 asserted 2 cycles into DOOR_OPEN at floor 4 -> all outputs 0, cur_floor=0 immediately, no further done.
REQ-034 req[5] with car at floor 5 in DOOR_OPEN re-pressed -> absorbed; IDLE after 3 cycles, no reopen.
